// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared access-size and FSM state types for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_ILL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_MEM = 2'b01,
    RESP     = 2'b10
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane enables, store replication, alignment check and load extension
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic        zero_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        bad,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = rdata >> {offset, 3'b000};
    be        = 4'b0000;
    wdata_rep = wdata;
    bad       = 1'b0;
    rdata_ext = 32'h0;
    case (size)
      SIZE_B: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{~zero_ext & shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        be        = 4'b0011 << {offset[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        bad       = offset[0];
        rdata_ext = {{16{~zero_ext & shifted[15]}}, shifted[15:0]};
      end
      SIZE_W: begin
        be        = 4'b1111;
        bad       = (offset != 2'b00);
        rdata_ext = shifted;
      end
      default: begin
        bad = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage: request FSM, request latches and response registers
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  state_e      state, state_next;
  logic        lat_write;
  size_e       lat_size;
  logic        lat_unsigned;
  logic [1:0]  lat_offset;

  size_e       al_size;
  logic [1:0]  al_offset;
  logic        al_zero_ext;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic        al_bad;
  logic [31:0] al_rdata;

  // In IDLE the aligner sees the live request; afterwards it sees the latched one for load extraction.
  always_comb begin
    if (state == IDLE) begin
      al_size     = size_e'(req_size);
      al_offset   = req_addr[1:0];
      al_zero_ext = req_unsigned;
    end else begin
      al_size     = lat_size;
      al_offset   = lat_offset;
      al_zero_ext = lat_unsigned;
    end
  end

  lsu_align u_align (
    .size      (al_size),
    .offset    (al_offset),
    .zero_ext  (al_zero_ext),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .bad       (al_bad),
    .rdata_ext (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (req_valid) state_next = al_bad ? RESP : WAIT_MEM;
      WAIT_MEM: if (mem_ack)   state_next = RESP;
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign stall     = ~req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_write    <= 1'b0;
      lat_size     <= SIZE_B;
      lat_unsigned <= 1'b0;
      lat_offset   <= 2'b00;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_be       <= 4'b0000;
      mem_wdata    <= 32'h0;
      resp_valid   <= 1'b0;
      resp_error   <= 1'b0;
      resp_rdata   <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write    <= req_write;
            lat_size     <= size_e'(req_size);
            lat_unsigned <= req_unsigned;
            lat_offset   <= req_addr[1:0];
            if (al_bad) begin
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= req_write;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= al_be;
              mem_wdata <= al_wdata;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= lat_write ? 32'h0 : al_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit against a byte-level model
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error, stall;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: accesses described as a run of bytes starting at the byte offset.
  function automatic bit m_bad(input int sz, input logic [31:0] addr);
    if (sz == 3) return 1'b1;
    return (int'(addr[1:0]) % (1 << sz)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input int sz, input logic [31:0] addr);
    logic [3:0] be = 4'b0000;
    int off = int'(addr[1:0]);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + (1 << sz));
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] wd);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = wd[(i % (1 << sz))*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdata(input int sz, input logic [31:0] addr, input bit uns,
                                          input logic [31:0] word);
    int     n   = 1 << sz;
    int     off = int'(addr[1:0]);
    longint v   = 0;
    for (int j = 0; j < n; j++) v += longint'(word[(off+j)*8 +: 8]) << (8*j);
    if (!uns && v >= (longint'(1) << (8*n - 1))) v -= longint'(1) << (8*n);
    return v[31:0];
  endfunction

  always @(negedge clk) if (mon_en) check("stall", {31'b0, stall}, {31'b0, ~req_ready});

  // lat = idle cycles before the ack; the ack lands in cycle lat+1 after acceptance.
  task automatic do_access(input bit w, input int sz, input bit uns, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int lat);
    bit bad;
    bad = m_bad(sz, addr);
    check("idle_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz[1:0]; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom_range(0, 3)); req_unsigned = 1'($urandom); req_write = 1'($urandom);
    if (bad) begin
      check("err_memreq", {31'b0, mem_req}, 32'd0);
      check("err_valid", {31'b0, resp_valid}, 32'd1);
      check("err_flag", {31'b0, resp_error}, 32'd1);
      check("err_rdata", resp_rdata, 32'h0);
      check("err_busy", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      check("err_memreq2", {31'b0, mem_req}, 32'd0);
      check("err_vdrop", {31'b0, resp_valid}, 32'd0);
      check("err_ready2", {31'b0, req_ready}, 32'd1);
    end else begin
      for (int c = 1; c <= lat + 1; c++) begin
        check("memreq", {31'b0, mem_req}, 32'd1);
        check("memwe", {31'b0, mem_we}, {31'b0, w});
        check("memaddr", mem_addr, {addr[31:2], 2'b00});
        check("membe", {28'b0, mem_be}, {28'b0, m_be(sz, addr)});
        if (w) check("memwdata", mem_wdata, m_wdata(sz, wd));
        check("early_resp", {31'b0, resp_valid}, 32'd0);
        mem_ack   = (c == lat + 1);
        mem_rdata = (c == lat + 1) ? rd : $urandom;
        @(negedge clk);
      end
      mem_ack = 1'b0; mem_rdata = $urandom;
      check("resp_valid", {31'b0, resp_valid}, 32'd1);
      check("resp_error", {31'b0, resp_error}, 32'd0);
      check("resp_rdata", resp_rdata, w ? 32'h0 : m_rdata(sz, addr, uns, rd));
      check("memreq_off", {31'b0, mem_req}, 32'd0);
      check("resp_busy", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      check("resp_drop", {31'b0, resp_valid}, 32'd0);
      check("ready_back", {31'b0, req_ready}, 32'd1);
    end
  endtask

  initial begin
    int pulses;
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge clk); @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_memreq", {31'b0, mem_req}, 32'd0);
    check("rst_memwe", {31'b0, mem_we}, 32'd0);
    check("rst_resp", {30'b0, resp_valid, resp_error}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_be", {28'b0, mem_be}, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    rst = 1'b0; mon_en = 1'b1;
    @(negedge clk);

    do_access(1'b0, 2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    do_access(1'b0, 0, 1'b0, 32'h103, 32'h0, 32'h80FFFF7F, 1);
    do_access(1'b0, 0, 1'b1, 32'h103, 32'h0, 32'h80FFFF7F, 1);
    do_access(1'b1, 1, 1'b0, 32'h206, 32'h1234ABCD, 32'h55555555, 0);
    do_access(1'b0, 2, 1'b0, 32'h101, 32'h0, 32'h0, 0);
    do_access(1'b0, 3, 1'b0, 32'h100, 32'h0, 32'h0, 0);
    do_access(1'b0, 1, 1'b0, 32'h102, 32'h0, 32'h8001ABCD, 2);

    // Stray acks while idle must not produce a response.
    mem_ack = 1'b1;
    @(negedge clk); @(negedge clk);
    check("stray_ack_resp", {31'b0, resp_valid}, 32'd0);
    check("stray_ack_ready", {31'b0, req_ready}, 32'd1);
    mem_ack = 1'b0;

    // Reset while waiting on memory, then a late ack.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h300; req_wdata = 32'hCAFEF00D;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    check("pre_rst_memreq", {31'b0, mem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_memreq", {31'b0, mem_req}, 32'd0);
    check("midrst_outs", {29'b0, mem_we, resp_valid, resp_error}, 32'd0);
    check("midrst_addr", mem_addr, 32'h0);
    check("midrst_wdata", mem_wdata, 32'h0);
    check("midrst_be", {28'b0, mem_be}, 32'h0);
    rst = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("late_ack_resp", {31'b0, resp_valid}, 32'd0);
    check("late_ack_memreq", {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    check("late_ack_resp2", {31'b0, resp_valid}, 32'd0);
    do_access(1'b0, 2, 1'b0, 32'h304, 32'h0, 32'h13579BDF, 1);

    // Back-to-back: accepts only in IDLE, every third cycle with a zero-wait memory.
    pulses = 0;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h40;
    mem_rdata = 32'hA5A50F0F;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      mem_ack = mem_req;
      if (resp_valid) begin
        pulses++;
        check("b2b_rdata", resp_rdata, 32'hA5A50F0F);
      end
      check("b2b_exclusive", {31'b0, mem_req & req_ready}, 32'd0);
      if (i == 8) req_valid = 1'b0;
    end
    mem_ack = 1'b0;
    check("b2b_pulses", pulses, 32'd3);
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'($urandom_range(0, 3)) & (($urandom_range(0, 1) != 0) ? 2'b00 : 2'b10);
      do_access(1'($urandom), $urandom_range(0, 3), 1'($urandom), a, $urandom, $urandom,
                $urandom_range(0, 4));
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
